// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider: start + operands in, busy/done + results out.
// Pure wiring, no latency of its own.
// No backpressure: the producer holds start until busy drops; results hold until the next done.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Requester side (drives operands, observes results)
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one trial subtraction per clock.
// Latency: done in the cycle after edge E+WIDTH (E = accepting edge); divide-by-zero after E+1.
// Backpressure: start is ignored while busy=1; start in the done cycle is accepted (no gap needed).
//   Ports: clk, rst (async active-high), bus (seq_divider_if.slave: start/dividend/divisor in,
//          busy/done/quotient/remainder/div_by_zero out).
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;      // dividend, shifting left; quotient bits enter the LSB
    logic [WIDTH-1:0] r_d;      // captured divisor
    logic [WIDTH-1:0] r_rem;    // partial remainder
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;

    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_a_next;

    // Trial subtraction one bit wider than the operands: the top bit is the borrow,
    // so a clear borrow means the divisor fit and the difference is kept.
    assign w_trial    = {r_rem, r_a[WIDTH-1]} - {1'b0, r_d};
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_a[WIDTH-1]};
    assign w_a_next   = {r_a[WIDTH-2:0], w_qbit};

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_q;
    assign bus.remainder   = r_r;
    assign bus.div_by_zero = r_dbz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_d     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_a   <= w_a_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_q     <= w_a_next;
                        r_r     <= w_rem_next;
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (r_state == S_DONE && r_busy) begin
                        // Divide-by-zero: DONE entered with busy still set, so this
                        // edge publishes the result and the next cycle is the done pulse.
                        r_q    <= '1;
                        r_r    <= r_a;
                        r_dbz  <= 1'b1;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        // IDLE, or the done cycle: both accept a new request.
                        r_done <= 1'b0;
                        if (bus.start) begin
                            r_a     <= bus.dividend;
                            r_d     <= bus.divisor;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= (bus.divisor == '0) ? S_DONE : S_RUN;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule
